// File: rtl/move_sequencer.sv
// move_sequencer
//   Decodes one 8-bit register-transfer instruction per accepted start and
//   drives the timed select/load strobes that make the register unit gate a
//   source onto the bus and capture it in the destination.
//
//   Optional feature macro: MOVE_SEQ_MOV16_EN
//     defined   : 8'hA0 is MOV16 XY<-M (sel_m_o / ld_xy_o strobes)
//     undefined : 8'hA0 is illegal, sel_m_o / ld_xy_o stay 0
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous, active-high reset
//   start_i      execute request, sampled only while idle
//   instr_i      instruction byte, captured on an accepted start
//   busy_o       high during T1..T[NUM_T]
//   done_o       one-cycle pulse in T[NUM_T] or in the error cycle
//   illegal_o    one-cycle pulse alongside done_o for unsupported opcodes
//   sel_r_o      one-hot source register select
//   ld_r_o       one-hot destination register load
//   sel_m_o      select M onto the address bus (MOV16 only)
//   ld_xy_o      load XY from the address bus (MOV16 only)
//   imm_oe_o     sequencer drives imm_data_o onto the data bus
//   imm_data_o   sign-extended immediate, 0 whenever imm_oe_o is low
module move_sequencer #(
  parameter int NUM_T     = 8,
  parameter int SEL_FIRST = 2,
  parameter int LD_FIRST  = 4,
  parameter int LD_LAST   = 5,
  parameter int SEL_LAST  = 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] instr_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       illegal_o,
  output logic [7:0] sel_r_o,
  output logic [7:0] ld_r_o,
  output logic       sel_m_o,
  output logic       ld_xy_o,
  output logic       imm_oe_o,
  output logic [7:0] imm_data_o
);

  localparam int TW = $clog2(NUM_T + 1);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_T);
  localparam logic [TW-1:0] SEL_F  = TW'(SEL_FIRST);
  localparam logic [TW-1:0] SEL_L  = TW'(SEL_LAST);
  localparam logic [TW-1:0] LD_F   = TW'(LD_FIRST);
  localparam logic [TW-1:0] LD_L   = TW'(LD_LAST);

  // The load window must sit strictly inside the select window so bus data
  // is stable on both sides of the capture.
  if (!(1 <= SEL_FIRST && SEL_FIRST < LD_FIRST && LD_FIRST <= LD_LAST &&
        LD_LAST < SEL_LAST && SEL_LAST < NUM_T)) begin : g_bad_params
    $error("move_sequencer: illegal T-state window parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;
  typedef enum logic [1:0] {OP_MOV8, OP_SETAB, OP_MOV16, OP_ILL} op_t;

  function automatic op_t decode(input logic [7:0] ins);
    op_t op;
    op = OP_ILL;
    if (ins[7:6] == 2'b00)      op = OP_MOV8;
    else if (ins[7:6] == 2'b01) op = OP_SETAB;
`ifdef MOVE_SEQ_MOV16_EN
    if (ins == 8'hA0)           op = OP_MOV16;
`endif
    return op;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [7:0]    instr_q, instr_d;
  op_t           op_q, op_d;
  op_t           instr_op;

  logic       busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [7:0] sel_r_q, sel_r_d, ld_r_q, ld_r_d, imm_data_q, imm_data_d;
  logic       sel_m_q, sel_m_d, ld_xy_q, ld_xy_d, imm_oe_q, imm_oe_d;
  logic       sel_win, ld_win;

  assign instr_op = decode(instr_i);

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    instr_d    = instr_q;
    op_d       = op_q;
    sel_r_d    = 8'h00;
    ld_r_d     = 8'h00;
    imm_oe_d   = 1'b0;
    imm_data_d = 8'h00;
    sel_m_d    = 1'b0;
    ld_xy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (instr_op == OP_ILL) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RUN;
            t_d     = TW'(1);
            instr_d = instr_i;
            op_d    = instr_op;
          end
        end
      end
      S_RUN: begin
        if (t_q == T_LAST) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;  // S_ERR lasts exactly one cycle
    endcase

    // Outputs are computed from the next state so they can be registered and
    // still line up with the T-state they belong to.
    sel_win   = (state_d == S_RUN) && (t_d >= SEL_F) && (t_d <= SEL_L);
    ld_win    = (state_d == S_RUN) && (t_d >= LD_F) && (t_d <= LD_L);
    busy_d    = (state_d == S_RUN);
    done_d    = ((state_d == S_RUN) && (t_d == T_LAST)) || (state_d == S_ERR);
    illegal_d = (state_d == S_ERR);

    if (state_d == S_RUN) begin
      case (op_d)
        OP_MOV8: begin
          // Self-move selects nothing: the destination captures an undriven bus.
          if (sel_win && (instr_d[5:3] != instr_d[2:0])) sel_r_d = 8'b1 << instr_d[2:0];
          if (ld_win) ld_r_d = 8'b1 << instr_d[5:3];
        end
        OP_SETAB: begin
          if (sel_win) begin
            imm_oe_d   = 1'b1;
            imm_data_d = {{3{instr_d[4]}}, instr_d[4:0]};
          end
          if (ld_win) ld_r_d = instr_d[5] ? 8'h02 : 8'h01;
        end
        OP_MOV16: begin
          sel_m_d = sel_win;
          ld_xy_d = ld_win;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      instr_q    <= 8'h00;
      op_q       <= OP_ILL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      sel_r_q    <= 8'h00;
      ld_r_q     <= 8'h00;
      sel_m_q    <= 1'b0;
      ld_xy_q    <= 1'b0;
      imm_oe_q   <= 1'b0;
      imm_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      instr_q    <= instr_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      sel_r_q    <= sel_r_d;
      ld_r_q     <= ld_r_d;
      sel_m_q    <= sel_m_d;
      ld_xy_q    <= ld_xy_d;
      imm_oe_q   <= imm_oe_d;
      imm_data_q <= imm_data_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign illegal_o  = illegal_q;
  assign sel_r_o    = sel_r_q;
  assign ld_r_o     = ld_r_q;
  assign imm_oe_o   = imm_oe_q;
  assign imm_data_o = imm_data_q;
`ifdef MOVE_SEQ_MOV16_EN
  assign sel_m_o    = sel_m_q;
  assign ld_xy_o    = ld_xy_q;
`else
  // Without MOV16 support op_q can never be OP_MOV16, so these registers
  // hold 0; the outputs are tied off explicitly.
  assign sel_m_o    = 1'b0 & sel_m_q;
  assign ld_xy_o    = 1'b0 & ld_xy_q;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: table of instructions with expected strobe
// patterns, plus hand-written sequences for async reset and back-to-back starts.
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       busy, done, illegal, sel_m, ld_xy, imm_oe;
  logic [7:0] sel_r, ld_r, imm_data;

  int checks = 0;
  int errors = 0;

  localparam int NT = 8;

  move_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .instr_i    (instr),
    .busy_o     (busy),
    .done_o     (done),
    .illegal_o  (illegal),
    .sel_r_o    (sel_r),
    .ld_r_o     (ld_r),
    .sel_m_o    (sel_m),
    .ld_xy_o    (ld_xy),
    .imm_oe_o   (imm_oe),
    .imm_data_o (imm_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] sel_r;     // value while in the select window (T2..T6)
    logic [7:0] ld_r;      // value while in the load window (T4..T5)
    logic       imm_oe;
    logic [7:0] imm_data;
    logic       sel_m;
    logic       ld_xy;
    logic       illegal;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},     {7'd0, busy},    8'h00);
    chk({tag, " done"},     {7'd0, done},    8'h00);
    chk({tag, " illegal"},  {7'd0, illegal}, 8'h00);
    chk({tag, " sel_r"},    sel_r,           8'h00);
    chk({tag, " ld_r"},     ld_r,            8'h00);
    chk({tag, " sel_m"},    {7'd0, sel_m},   8'h00);
    chk({tag, " ld_xy"},    {7'd0, ld_xy},   8'h00);
    chk({tag, " imm_oe"},   {7'd0, imm_oe},  8'h00);
    chk({tag, " imm_data"}, imm_data,        8'h00);
  endtask

  // Applies one vector starting at a falling edge; returns at the falling
  // edge of the idle cycle that follows the instruction.
  task automatic run_vec(input vec_t v);
    string tag;
    bit    sw, lw;
    @(negedge clk);
    start = 1'b1;
    instr = v.instr;
    @(negedge clk);
    start = 1'b0;
    instr = 8'hFF;  // changes after acceptance must be ignored
    if (v.illegal) begin
      tag = $sformatf("i%h err", v.instr);
      chk({tag, " done"},    {7'd0, done},    8'h01);
      chk({tag, " illegal"}, {7'd0, illegal}, 8'h01);
      chk({tag, " busy"},    {7'd0, busy},    8'h00);
      chk({tag, " sel_r"},   sel_r,           8'h00);
      chk({tag, " ld_r"},    ld_r,            8'h00);
      chk({tag, " sel_m"},   {7'd0, sel_m},   8'h00);
      chk({tag, " ld_xy"},   {7'd0, ld_xy},   8'h00);
      chk({tag, " imm_oe"},  {7'd0, imm_oe},  8'h00);
      @(negedge clk);
      chk_all_zero($sformatf("i%h after err", v.instr));
    end else begin
      for (int t = 1; t <= NT; t++) begin
        tag = $sformatf("i%h T%0d", v.instr, t);
        sw = (t >= 2 && t <= 6);
        lw = (t >= 4 && t <= 5);
        chk({tag, " busy"},     {7'd0, busy},    8'h01);
        chk({tag, " done"},     {7'd0, done},    {7'd0, t == NT});
        chk({tag, " illegal"},  {7'd0, illegal}, 8'h00);
        chk({tag, " sel_r"},    sel_r,           sw ? v.sel_r : 8'h00);
        chk({tag, " ld_r"},     ld_r,            lw ? v.ld_r : 8'h00);
        chk({tag, " imm_oe"},   {7'd0, imm_oe},  {7'd0, sw & v.imm_oe});
        chk({tag, " imm_data"}, imm_data,        (sw && v.imm_oe) ? v.imm_data : 8'h00);
        chk({tag, " sel_m"},    {7'd0, sel_m},   {7'd0, sw & v.sel_m});
        chk({tag, " ld_xy"},    {7'd0, ld_xy},   {7'd0, lw & v.ld_xy});
        if (t < NT) @(negedge clk);
      end
      @(negedge clk);
      chk_all_zero($sformatf("i%h idle", v.instr));
    end
    $display("transaction instr=%h illegal=%0d checks=%0d errors=%0d",
             v.instr, v.illegal, checks, errors);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //                instr  sel_r  ld_r   oe    imm    sel_m ld_xy ill
    vecs[0] = '{8'h01, 8'h02, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}; // A<-B
    vecs[1] = '{8'h7B, 8'h00, 8'h02, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b0}; // SETAB B,-5
    vecs[2] = '{8'h5B, 8'h00, 8'h01, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b0}; // SETAB A,-5
    vecs[3] = '{8'h12, 8'h00, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}; // C<-C
    vecs[4] = '{8'h3E, 8'h40, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}; // Y<-X
    vecs[5] = '{8'h4F, 8'h00, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0}; // SETAB A,+15
    vecs[6] = '{8'h60, 8'h00, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}; // SETAB B,0
    vecs[7] = '{8'hC3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}; // illegal
`ifdef MOVE_SEQ_MOV16_EN
    vecs[8] = '{8'hA0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}; // MOV16
`else
    vecs[8] = '{8'hA0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}; // illegal
`endif
    vecs[9] = '{8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}; // illegal

    reset = 1'b0;
    start = 1'b0;
    instr = 8'h00;
    #1 reset = 1'b1;
    #2 chk_all_zero("reset before clock");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle after reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start held high: reset in T4 clears outputs without a clock edge.
    @(negedge clk);
    start = 1'b1;
    instr = 8'h01;
    repeat (4) @(negedge clk);   // now in T4
    chk("held T4 ld_r", ld_r, 8'h01);
    chk("held T4 sel_r", sel_r, 8'h02);
    #2 reset = 1'b1;
    #1 chk_all_zero("async reset T4");
    @(negedge clk);
    chk_all_zero("reset held");
    reset = 1'b0;
    @(negedge clk);              // accepted at first edge after release: T1
    chk("post-reset T1 busy", {7'd0, busy}, 8'h01);
    chk("post-reset T1 sel_r", sel_r, 8'h00);
    @(negedge clk);              // T2
    chk("post-reset T2 sel_r", sel_r, 8'h02);
    repeat (6) @(negedge clk);   // T8
    chk("held T8 done", {7'd0, done}, 8'h01);
    chk("held T8 busy", {7'd0, busy}, 8'h01);
    @(negedge clk);              // idle: start during busy was not queued
    chk("held idle busy", {7'd0, busy}, 8'h00);
    chk("held idle done", {7'd0, done}, 8'h00);
    @(negedge clk);              // back-to-back acceptance
    chk("back-to-back T1 busy", {7'd0, busy}, 8'h01);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk_all_zero("final idle");
    $display("transaction held-start/reset sequence checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
